// File: rtl/irq_controller_if.sv
// CPU-side bus between the system glue logic and irq_controller:
// register writes, acknowledge/end-of-interrupt strobes and status readback.
interface irq_controller_if #(
    parameter int CHANNELS = 8
);
    localparam int VW = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1;

    logic                wr_enable;
    logic [1:0]          wr_addr;
    logic [CHANNELS-1:0] wr_data;
    logic                iack;
    logic                eoi;
    logic                irq;
    logic [VW-1:0]       vector;
    logic                in_service;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] mask;

    modport master (
        output wr_enable, wr_addr, wr_data, iack, eoi,
        input  irq, vector, in_service, pending, mask
    );

    modport slave (
        input  wr_enable, wr_addr, wr_data, iack, eoi,
        output irq, vector, in_service, pending, mask
    );
endinterface

// File: rtl/irq_controller.sv
// Parametrised interrupt controller: synchronised edge/level sources, pending
// and mask registers, highest-index priority and an assert/ack/EOI handshake.
module irq_controller #(
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] irq_in,
    input  logic [CHANNELS-1:0] edge_mode,
    irq_controller_if.slave     bus
);
    localparam int VW = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_SERVICE} state_t;

    state_t              state;
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] s_d;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] pending_q;
    logic [CHANNELS-1:0] mask_q;
    logic [CHANNELS-1:0] active;
    logic [CHANNELS-1:0] clr;
    logic [CHANNELS-1:0] pend_next;
    logic [VW-1:0]       top;
    logic [VW-1:0]       vector_q;
    logic                any;
    logic                take_iack;
    logic                irq_q;
    logic                svc_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
            s_d <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int unsigned j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
            s_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s         = sync_q[SYNC_STAGES-1];
    assign rise      = s & ~s_d;
    assign active    = pending_q & mask_q;
    assign any       = |active;
    assign take_iack = (state == ST_ASSERT) && bus.iack && any;

    always_comb begin
        top = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (active[i]) top = VW'(i);
        end
    end

    // Rise is OR-ed in after the clear so a coincident new edge survives W1C/iack.
    always_comb begin
        clr = '0;
        if (bus.wr_enable && bus.wr_addr == 2'd3) clr = bus.wr_data;
        if (take_iack) clr[vector_q] = 1'b1;
        pend_next = (edge_mode & ((pending_q & ~clr) | rise)) | (~edge_mode & s);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            pending_q <= pend_next;
            if (bus.wr_enable) begin
                case (bus.wr_addr)
                    2'd0:    mask_q <= bus.wr_data;
                    2'd1:    mask_q <= mask_q | bus.wr_data;
                    2'd2:    mask_q <= mask_q & ~bus.wr_data;
                    default: mask_q <= mask_q;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            irq_q    <= 1'b0;
            svc_q    <= 1'b0;
            vector_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    vector_q <= top;
                    if (any) begin
                        state <= ST_ASSERT;
                        irq_q <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    if (!any) begin
                        state    <= ST_IDLE;
                        irq_q    <= 1'b0;
                        vector_q <= top;
                    end else if (bus.iack) begin
                        state <= ST_SERVICE;
                        irq_q <= 1'b0;
                        svc_q <= 1'b1;
                    end else begin
                        vector_q <= top;
                    end
                end
                ST_SERVICE: begin
                    if (bus.eoi) begin
                        state <= ST_IDLE;
                        svc_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    irq_q <= 1'b0;
                    svc_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq        = irq_q;
    assign bus.vector     = vector_q;
    assign bus.in_service = svc_q;
    assign bus.pending    = pending_q;
    assign bus.mask       = mask_q;
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a delay-line behavioural model.
module tb_irq_controller;
    localparam int CH   = 8;
    localparam int SYNC = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [CH-1:0] irq_in = '0;
    logic [CH-1:0] edge_mode = 8'hEF;
    logic [31:0]   irq_in32 = '0;
    logic [31:0]   edge_mode32 = '1;

    int passes = 0;
    int total  = 0;

    irq_controller_if #(.CHANNELS(CH)) bus ();
    irq_controller_if #(.CHANNELS(32)) bus32 ();

    irq_controller #(.CHANNELS(CH), .SYNC_STAGES(SYNC)) dut (
        .clock(clock), .reset_n(reset_n), .irq_in(irq_in),
        .edge_mode(edge_mode), .bus(bus)
    );

    irq_controller #(.CHANNELS(32), .SYNC_STAGES(SYNC)) dut32 (
        .clock(clock), .reset_n(reset_n), .irq_in(irq_in32),
        .edge_mode(edge_mode32), .bus(bus32)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else passes++;
    endtask

    // Behavioural model: dl[0] holds the newest sampled input, so the
    // synchronised value is SYNC-1 entries back and its predecessor one further.
    typedef enum {M_IDLE, M_ASSERT, M_SERVICE} mstate_t;
    mstate_t       m_state;
    logic [CH-1:0] dl [$];
    logic [CH-1:0] m_pend, m_mask, ms, msd, mact, mclr, mnp;
    logic [2:0]    m_vec;
    logic          m_irq, m_svc, many;
    int            mtop;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_state = M_IDLE; m_pend = '0; m_mask = '0; m_vec = '0; m_irq = 0; m_svc = 0;
            dl.delete();
            repeat (SYNC + 1) dl.push_back('0);
        end else begin
            ms   = dl[SYNC-1];
            msd  = dl[SYNC];
            mact = m_pend & m_mask;
            many = (mact != 0);
            mtop = many ? $clog2(int'(mact) + 1) - 1 : 0;
            mclr = (bus.wr_enable && bus.wr_addr == 2'd3) ? bus.wr_data : '0;
            if (m_state == M_ASSERT && bus.iack && many) mclr[m_vec] = 1'b1;
            mnp = m_pend;
            for (int i = 0; i < CH; i++) begin
                if (edge_mode[i]) begin
                    if (ms[i] && !msd[i]) mnp[i] = 1'b1;
                    else if (mclr[i]) mnp[i] = 1'b0;
                end else begin
                    mnp[i] = ms[i];
                end
            end
            if (bus.wr_enable) begin
                if (bus.wr_addr == 2'd0) m_mask = bus.wr_data;
                else if (bus.wr_addr == 2'd1) m_mask = m_mask | bus.wr_data;
                else if (bus.wr_addr == 2'd2) m_mask = m_mask & ~bus.wr_data;
            end
            case (m_state)
                M_IDLE: begin
                    m_vec = 3'(mtop);
                    if (many) begin m_state = M_ASSERT; m_irq = 1; end
                end
                M_ASSERT: begin
                    if (!many) begin m_state = M_IDLE; m_irq = 0; m_vec = 3'(mtop); end
                    else if (bus.iack) begin m_state = M_SERVICE; m_irq = 0; m_svc = 1; end
                    else m_vec = 3'(mtop);
                end
                default: if (bus.eoi) begin m_state = M_IDLE; m_svc = 0; end
            endcase
            m_pend = mnp;
            dl.push_front(irq_in);
            void'(dl.pop_back());
        end
    end

    always @(posedge clock) begin
        #1;
        chk("model_irq", 32'(bus.irq), 32'(m_irq));
        chk("model_vector", 32'(bus.vector), 32'(m_vec));
        chk("model_in_service", 32'(bus.in_service), 32'(m_svc));
        chk("model_pending", 32'(bus.pending), 32'(m_pend));
        chk("model_mask", 32'(bus.mask), 32'(m_mask));
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic wr(input logic [1:0] addr, input logic [CH-1:0] data);
        bus.wr_enable = 1; bus.wr_addr = addr; bus.wr_data = data;
        tick();
        bus.wr_enable = 0;
    endtask

    task automatic service();
        bus.iack = 1; tick(); bus.iack = 0;
        bus.eoi = 1;  tick(); bus.eoi = 0;
    endtask

    initial begin
        bus.wr_enable = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.iack = 0; bus.eoi = 0;
        bus32.wr_enable = 0; bus32.wr_addr = '0; bus32.wr_data = '0; bus32.iack = 0; bus32.eoi = 0;
        repeat (3) tick();
        chk("reset_irq", 32'(bus.irq), 0);
        chk("reset_pending", 32'(bus.pending), 0);
        chk("reset_mask", 32'(bus.mask), 0);
        reset_n = 1;
        tick();
        wr(2'd0, 8'hFF);

        // single edge on channel 3
        irq_in[3] = 1; tick(); irq_in[3] = 0; tick(); tick();
        chk("ch3_pending", 32'(bus.pending), 32'h08);
        chk("ch3_irq_not_yet", 32'(bus.irq), 0);
        tick();
        chk("ch3_irq", 32'(bus.irq), 1);
        chk("ch3_vector", 32'(bus.vector), 3);
        service();
        chk("ch3_cleared", 32'(bus.pending), 0);

        // channels 2 and 5 together: 5 first, then 2
        irq_in = 8'h24; tick(); irq_in = '0; repeat (3) tick();
        chk("c25_vector", 32'(bus.vector), 5);
        bus.iack = 1; tick(); bus.iack = 0;
        chk("c25_pending_after_iack", 32'(bus.pending), 32'h04);
        chk("c25_in_service", 32'(bus.in_service), 1);
        chk("c25_irq_low", 32'(bus.irq), 0);
        chk("c25_vector_held", 32'(bus.vector), 5);
        bus.eoi = 1; tick(); bus.eoi = 0;
        chk("c25_eoi_idle", 32'(bus.in_service), 0);
        tick();
        chk("c25_reassert", 32'(bus.irq), 1);
        chk("c25_vector2", 32'(bus.vector), 2);
        service(); tick();
        chk("c25_all_clear", 32'(bus.pending), 0);
        chk("c25_irq_off", 32'(bus.irq), 0);

        // retarget from channel 1 to 6 while in ASSERT
        irq_in[1] = 1; tick(); irq_in[1] = 0; repeat (3) tick();
        chk("rt_vector1", 32'(bus.vector), 1);
        irq_in[6] = 1; tick(); irq_in[6] = 0; tick(); tick();
        chk("rt_pend6", 32'(bus.pending), 32'h42);
        chk("rt_vector_still1", 32'(bus.vector), 1);
        tick();
        chk("rt_vector6", 32'(bus.vector), 6);
        bus.iack = 1; tick(); bus.iack = 0;
        chk("rt_serviced6", 32'(bus.pending), 32'h02);
        bus.eoi = 1; tick(); bus.eoi = 0;
        tick(); service();

        // level channel 4
        irq_in[4] = 1; repeat (4) tick();
        chk("lvl_vector4", 32'(bus.vector), 4);
        service();
        chk("lvl_pending_kept", 32'(bus.pending), 32'h10);
        tick();
        chk("lvl_reassert", 32'(bus.irq), 1);
        irq_in[4] = 0; repeat (3) tick();
        chk("lvl_pending_drop", 32'(bus.pending), 0);
        chk("lvl_irq_still", 32'(bus.irq), 1);
        tick();
        chk("lvl_withdrawn", 32'(bus.irq), 0);

        // mask clear / set on channel 0
        irq_in[0] = 1; tick(); irq_in[0] = 0; repeat (3) tick();
        chk("mk_irq", 32'(bus.irq), 1);
        wr(2'd2, 8'h01);
        chk("mk_cleared", 32'(bus.mask), 32'hFE);
        tick();
        chk("mk_irq_off", 32'(bus.irq), 0);
        chk("mk_pend_kept", 32'(bus.pending), 32'h01);
        wr(2'd1, 8'h01); tick();
        chk("mk_irq_back", 32'(bus.irq), 1);
        service();

        // set wins over W1C on channel 7, then reset during SERVICE
        irq_in[7] = 1; tick(); irq_in[7] = 0; tick();
        wr(2'd3, 8'h80);
        chk("sw_set_wins", 32'(bus.pending), 32'h80);
        tick();
        chk("sw_vector7", 32'(bus.vector), 7);
        bus.iack = 1; tick(); bus.iack = 0;
        chk("sw_in_service", 32'(bus.in_service), 1);
        #2 reset_n = 0;
        #1;
        chk("ar_irq", 32'(bus.irq), 0);
        chk("ar_in_service", 32'(bus.in_service), 0);
        chk("ar_pending", 32'(bus.pending), 0);
        chk("ar_mask", 32'(bus.mask), 0);
        chk("ar_vector", 32'(bus.vector), 0);

        // randomized run
        edge_mode = 8'($urandom);
        tick(); reset_n = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < CH; b++) if ($urandom_range(15) == 0) irq_in[b] = ~irq_in[b];
            bus.wr_enable = ($urandom_range(7) == 0);
            bus.wr_addr   = 2'($urandom);
            bus.wr_data   = 8'($urandom);
            bus.iack      = ($urandom_range(3) == 0);
            bus.eoi       = ($urandom_range(3) == 0);
            tick();
        end
        bus.wr_enable = 0; bus.iack = 0; bus.eoi = 0;

        // 32-channel instance: top channel wins
        bus32.wr_enable = 1; bus32.wr_addr = 2'd0; bus32.wr_data = '1;
        tick(); bus32.wr_enable = 0;
        irq_in32 = 32'h8000_0001; tick(); irq_in32 = '0; repeat (3) tick();
        chk("w32_irq", 32'(bus32.irq), 1);
        chk("w32_vector", 32'(bus32.vector), 31);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
